// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rst_n.
// Optional lock-loss counter enabled by defining PLL_RST_CTRL_LOSS_CNT_EN.
module pll_reset_ctrl #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned LOCK_TIMEOUT = 50000,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked_in,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state_dbg
);

    // Handshake semantics: clear_fault is a one-cycle request that is acted on only
    // in FAULT and ignored elsewhere; ready is a level status, high exactly in RUN.

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]  RETRY_MAX    = 4'(MAX_RETRY);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [3:0]  retry_nxt;
    logic        locked_meta;
    logic        locked_s;

    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 16'd1;
        retry_nxt = retry_cnt;
        case (state)
            S_RESET_PLL: begin
                if (cnt == RST_LAST) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = S_STABILIZE;
                    cnt_nxt   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_nxt = retry_cnt + 4'd1;
                    state_nxt = (retry_nxt == RETRY_MAX) ? S_FAULT : S_RESET_PLL;
                    cnt_nxt   = '0;
                end
            end
            S_STABILIZE: begin
                if (!locked_s) begin
                    state_nxt = S_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            end
            S_RUN: begin
                // Counter is idle here; hold it at zero rather than letting it wrap.
                cnt_nxt = '0;
                if (!locked_s) begin
                    state_nxt = S_RESET_PLL;
                end
            end
            S_FAULT: begin
                cnt_nxt = '0;
                if (clear_fault) begin
                    state_nxt = S_RESET_PLL;
                    retry_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_RESET_PLL;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from state_nxt so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
            state       <= S_RESET_PLL;
            cnt         <= '0;
            retry_cnt   <= '0;
            pll_rst     <= 1'b1;
            sys_rst_n   <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            locked_meta <= locked_in;
            locked_s    <= locked_meta;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            retry_cnt   <= retry_nxt;
            pll_rst     <= (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
            sys_rst_n   <= (state_nxt == S_RUN);
            ready       <= (state_nxt == S_RUN);
            fault       <= (state_nxt == S_FAULT);
        end
    end

`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    logic loss_event;

    assign loss_event = (state == S_RUN) && !locked_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (loss_event && (loss_cnt != 8'hFF)) begin
            loss_cnt <= loss_cnt + 8'd1;
        end
    end
`else
    assign loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Randomised scoreboard bench for pll_reset_ctrl against a phase/countdown reference model.
module tb_pll_reset_ctrl;

  localparam int RST_CYCLES   = 4;
  localparam int LOCK_STABLE  = 8;
  localparam int LOCK_TIMEOUT = 20;
  localparam int MAX_RETRY    = 2;

  localparam int M_PULSE  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_SETTLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAULT  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset_n;
  logic       locked_in;
  logic       clear_fault;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state_dbg;

  always #10 clk = ~clk;

  pll_reset_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_STABLE  (LOCK_STABLE),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .clear_fault (clear_fault),
    .pll_rst     (pll_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .loss_cnt    (loss_cnt),
    .state_dbg   (state_dbg)
  );

  logic [15:0] got;
  assign got = {pll_rst, sys_rst_n, ready, fault, retry_cnt, loss_cnt};

  // ---------------- reference model ----------------
  int         m_mode;
  int         m_left;
  int         m_retries;
  int         m_losses;
  logic [1:0] m_sync;

  function automatic void model_reset();
    m_mode    = M_PULSE;
    m_left    = RST_CYCLES;
    m_retries = 0;
    m_losses  = 0;
    m_sync    = 2'b00;
  endfunction

  function automatic void model_edge(input logic lin, input logic clr);
    logic seen;
    seen   = m_sync[1];
    m_sync = {m_sync[0], lin};
    case (m_mode)
      M_PULSE: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_mode = M_WAIT;
          m_left = LOCK_TIMEOUT;
        end
      end
      M_WAIT: begin
        if (seen) begin
          m_mode = M_SETTLE;
          m_left = LOCK_STABLE;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_retries = m_retries + 1;
            if (m_retries == MAX_RETRY) begin
              m_mode = M_FAULT;
            end else begin
              m_mode = M_PULSE;
              m_left = RST_CYCLES;
            end
          end
        end
      end
      M_SETTLE: begin
        if (!seen) begin
          m_mode = M_WAIT;
          m_left = LOCK_TIMEOUT;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode    = M_RUN;
            m_retries = 0;
          end
        end
      end
      M_RUN: begin
        if (!seen) begin
          m_mode = M_PULSE;
          m_left = RST_CYCLES;
          if (m_losses < 255) m_losses = m_losses + 1;
        end
      end
      default: begin
        if (clr) begin
          m_mode    = M_PULSE;
          m_left    = RST_CYCLES;
          m_retries = 0;
        end
      end
    endcase
  endfunction

  function automatic logic [15:0] model_out();
    logic [7:0] loss;
`ifdef PLL_RST_CTRL_LOSS_CNT_EN
    loss = 8'(m_losses);
`else
    loss = 8'd0;
`endif
    return {(m_mode == M_PULSE) || (m_mode == M_FAULT), m_mode == M_RUN, m_mode == M_RUN,
            m_mode == M_FAULT, 4'(m_retries), loss};
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always @(negedge clk) begin
    logic [15:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL outputs t=%0t: got %h required %h (pll_rst,sys_rst_n,ready,fault,retry[3:0],loss[7:0])",
                 $time, got, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic lin, input logic clr, input logic rn);
    @(posedge clk);
    #1;
    if (!reset_n) model_reset();
    else          model_edge(locked_in, clear_fault);
    exp_q.push_back(model_out());
    locked_in   = lin;
    clear_fault = clr;
    reset_n     = rn;
  endtask

  task automatic hold(input logic lin, input int n, input bit rand_clr);
    for (int i = 0; i < n; i++) begin
      cycle(lin, rand_clr ? ($urandom_range(0, 15) == 0) : 1'b0, 1'b1);
    end
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (got !== 16'h8000) begin
      n_bad++;
      $display("FAIL async_reset t=%0t: got %h required %h", $time, got, 16'h8000);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n     = 1'b0;
    locked_in   = 1'b0;
    clear_fault = 1'b0;
    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1);

    // Lock arrives at cycle 10; a stray clear_fault during WAIT_LOCK must be ignored.
    for (int c = 0; c < 40; c++) cycle(c >= 10, c == 5, 1'b1);

    // Single-cycle lock loss in RUN, then reacquire.
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 30, 1'b0);

    // Lock never arrives: retries exhaust into FAULT, then clear it.
    hold(1'b0, 70, 1'b0);
    cycle(1'b0, 1'b1, 1'b1);
    hold(1'b0, 3, 1'b0);

    // Glitch during STABILIZE, then a clean acquire.
    hold(1'b0, 20, 1'b0);
    hold(1'b1, 8, 1'b0);
    hold(1'b0, 1, 1'b0);
    hold(1'b1, 30, 1'b0);

    // Random lock activity with sporadic clear_fault pulses.
    for (int s = 0; s < 150; s++) begin
      hold(1'($urandom_range(0, 1)), $urandom_range(1, 40), 1'b1);
    end

    // Repeated lock losses to drive the loss counter into saturation.
    for (int k = 0; k < 320; k++) begin
      hold(1'b1, $urandom_range(20, 26), 1'b0);
      hold(1'b0, 1, 1'b0);
    end

    // Asynchronous reset in the middle of RUN.
    hold(1'b1, 30, 1'b0);
    async_reset_check();
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    hold(1'b1, 30, 1'b0);
    hold(1'b0, 2, 1'b0);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
